// File: rtl/chip_uart_tx.sv
// chip_uart_tx: sends a 16-bit word as two back-to-back 8N1 UART frames.
// Define CHIP_UART_TX_PARITY_EN to add an even-parity bit after each byte's data bits.
module chip_uart_tx #(
   parameter int CLK_DIV   = 434,
   parameter int BYTE_SWAP = 0
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic [15:0] tx_data,
   input  logic        tx_vld,
   output logic        tx_done,
   output logic        tx_busy,
   output logic        tx_ovf,
   output logic        uart_tx
);

   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

`ifdef CHIP_UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t      state;
   logic [15:0] cnt;
   logic [15:0] hold;
   logic [2:0]  bit_idx;
   logic        byte_sel;
   logic [7:0]  cur_byte;

   // byte_sel counts transmitted bytes; BYTE_SWAP flips which half goes first
   assign cur_byte = (byte_sel ^ (BYTE_SWAP != 0)) ? hold[15:8] : hold[7:0];

   // The line value is registered alongside each state change, so uart_tx
   // always reflects the state being entered on the same edge.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         hold     <= '0;
         bit_idx  <= '0;
         byte_sel <= 1'b0;
         uart_tx  <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         tx_ovf   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         tx_ovf  <= tx_vld && tx_busy;
         case (state)
            S_IDLE: begin
               if (tx_vld) begin
                  hold     <= tx_data;
                  state    <= S_START;
                  cnt      <= DIV_M1;
                  byte_sel <= 1'b0;
                  tx_busy  <= 1'b1;
                  uart_tx  <= 1'b0;
               end
            end
            S_START: begin
               if (cnt == '0) begin
                  state   <= S_DATA;
                  cnt     <= DIV_M1;
                  bit_idx <= '0;
                  uart_tx <= cur_byte[0];
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (cnt == '0) begin
                  cnt <= DIV_M1;
                  if (bit_idx == 3'd7) begin
`ifdef CHIP_UART_TX_PARITY_EN
                     state   <= S_PARITY;
                     uart_tx <= ^cur_byte;
`else
                     state   <= S_STOP;
                     uart_tx <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
`ifdef CHIP_UART_TX_PARITY_EN
            S_PARITY: begin
               if (cnt == '0) begin
                  state   <= S_STOP;
                  cnt     <= DIV_M1;
                  uart_tx <= 1'b1;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (cnt == '0) begin
                  if (!byte_sel) begin
                     // second byte follows with no idle gap
                     state    <= S_START;
                     cnt      <= DIV_M1;
                     byte_sel <= 1'b1;
                     uart_tx  <= 1'b0;
                  end else begin
                     state    <= S_IDLE;
                     byte_sel <= 1'b0;
                     tx_busy  <= 1'b0;
                     tx_done  <= 1'b1;
                     uart_tx  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state   <= S_IDLE;
               tx_busy <= 1'b0;
               uart_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chip_uart_tx.sv
// tb_chip_uart_tx: random words into two transmitters (BYTE_SWAP 0 and 1),
// scoreboarded against a bit-level frame model.
module tb_chip_uart_tx;

   localparam int DIV = 4;
`ifdef CHIP_UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int BLEN = PAR ? 11 : 10;     // line bits per byte frame
   localparam int NB   = 2 * BLEN;          // line bits per word
   localparam int WT   = NB * DIV + 1;      // acceptance to tx_done

   typedef struct {
      int          start;
      logic [15:0] word;
   } exp_t;

   logic        clk_sys = 1'b0;
   logic        rst_n   = 1'b0;
   logic [15:0] tx_data = '0;
   logic        tx_vld  = 1'b0;
   logic [1:0]  line, busy, done, ovf;

   int   cyc = 0;
   int   free_at = 0;
   bit   end_req = 1'b0;
   exp_t exp_q[$];
   int   ovf_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   bit          act[2];
   int          t0[2], ferr[2], rd[2], ovf_rd[2];
   logic [15:0] wexp[2], obs[2];

   chip_uart_tx #(.CLK_DIV(DIV), .BYTE_SWAP(0)) u_dut0 (
      .clk_sys(clk_sys), .rst_n(rst_n), .tx_data(tx_data), .tx_vld(tx_vld),
      .tx_done(done[0]), .tx_busy(busy[0]), .tx_ovf(ovf[0]), .uart_tx(line[0]));

   chip_uart_tx #(.CLK_DIV(DIV), .BYTE_SWAP(1)) u_dut1 (
      .clk_sys(clk_sys), .rst_n(rst_n), .tx_data(tx_data), .tx_vld(tx_vld),
      .tx_done(done[1]), .tx_busy(busy[1]), .tx_ovf(ovf[1]), .uart_tx(line[1]));

   initial forever #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Line level expected during line-bit j of a word frame
   function automatic logic exp_bit(input logic [15:0] w, input bit swap, input int j);
      logic [7:0] b;
      int pos;
      b   = (((j / BLEN) == 0) != swap) ? w[7:0] : w[15:8];
      pos = j % BLEN;
      if (pos == 0) return 1'b0;
      if (pos <= 8) return b[pos-1];
      if (PAR && pos == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", nm, g, cyc, got, want);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      forever begin
         @(negedge clk_sys or negedge rst_n);
         if (clk_sys === 1'b1) begin
            #1;
            for (int g = 0; g < 2; g++) begin
               chk("async_rst_line", g, 32'(line[g]), 32'd1);
               chk("async_rst_busy", g, 32'(busy[g]), 32'd0);
            end
         end else if (end_req) begin
            for (int g = 0; g < 2; g++) begin
               chk("words_seen", g, rd[g], exp_q.size());
               chk("ovf_seen", g, ovf_rd[g], ovf_q.size());
               chk("idle_at_end", g, 32'(act[g]), 32'd0);
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
         end else if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
               act[g] = 1'b0; rd[g] = 0; ovf_rd[g] = 0;
               chk("rst_line", g, 32'(line[g]), 32'd1);
               chk("rst_busy", g, 32'(busy[g]), 32'd0);
               chk("rst_done", g, 32'(done[g]), 32'd0);
               chk("rst_ovf",  g, 32'(ovf[g]),  32'd0);
            end
         end else begin
            for (int g = 0; g < 2; g++) begin
               int k, j, pos;
               logic [15:0] w;
               if (ovf[g]) begin
                  if (ovf_rd[g] < ovf_q.size()) begin
                     chk("ovf_cycle", g, cyc, ovf_q[ovf_rd[g]]);
                     ovf_rd[g]++;
                  end else chk("ovf_spurious", g, 32'd1, 32'd0);
               end
               if (!act[g]) begin
                  if (done[g]) chk("done_spurious", g, 32'd1, 32'd0);
                  if (!line[g]) begin
                     act[g] = 1'b1; t0[g] = cyc; ferr[g] = 0; obs[g] = '0;
                     if (rd[g] < exp_q.size()) begin
                        chk("start_cycle", g, cyc, exp_q[rd[g]].start);
                        wexp[g] = exp_q[rd[g]].word;
                        rd[g]++;
                     end else begin
                        chk("start_spurious", g, 32'd1, 32'd0);
                        wexp[g] = '0;
                     end
                  end
               end
               if (act[g]) begin
                  k = cyc - t0[g];
                  if (k < NB * DIV) begin
                     j = k / DIV;
                     if (line[g] !== exp_bit(wexp[g], g == 1, j) || busy[g] !== 1'b1 || done[g] !== 1'b0)
                        ferr[g]++;
                     pos = j % BLEN;
                     if (k % DIV == DIV / 2 && pos >= 1 && pos <= 8)
                        obs[g][(j / BLEN) * 8 + pos - 1] = line[g];
                  end else begin
                     chk("done_pulse", g, 32'(done[g]), 32'd1);
                     chk("busy_clear", g, 32'(busy[g]), 32'd0);
                     chk("frame_wave_errs", g, ferr[g], 32'd0);
                     w = (g == 1) ? {obs[g][7:0], obs[g][15:8]} : obs[g];
                     chk("word_decoded", g, 32'(w), 32'(wexp[g]));
                     act[g] = 1'b0;
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus + reference timing model ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic send(input logic [15:0] w);
      exp_t e;
      tx_data = w;
      tx_vld  = 1'b1;
      if (cyc >= free_at) begin
         e.start = cyc + 1;
         e.word  = w;
         exp_q.push_back(e);
         free_at = cyc + WT;
      end else begin
         ovf_q.push_back(cyc + 1);
      end
      idle(1);
      tx_vld  = 1'b0;
      tx_data = 16'($urandom);
   endtask

   initial begin
      idle(3);
      rst_n = 1'b1;
      idle(2);
      send(16'hA53C);
      idle(WT + 3);
      send(16'h0301);
      idle(WT + 3);
      // overflow request ten cycles after the first
      send(16'h5AC3);
      idle(9);
      send(16'hFFFF);
      while (cyc < free_at) idle(1);
      // back-to-back: request in the tx_done cycle
      send(16'hBEEF);
      while (cyc < free_at) idle(1);
      send(16'h1234);
      idle(WT + 2);
      // reset thirty cycles into a word
      send(16'h9696);
      idle(29);
      rst_n = 1'b0;
      exp_q.delete();
      ovf_q.delete();
      free_at = 0;
      idle(2);
      rst_n = 1'b1;
      send(16'h00FF);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            while (cyc < free_at) idle(1);
         end else begin
            idle($urandom_range(0, WT + 4));
         end
         send(16'($urandom));
      end
      while (cyc < free_at + 2) idle(1);
      end_req = 1'b1;
   end

   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/chip_uart_tx.md
CHIP_UART_TX -- requirements
Module: chip_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, clk_sys cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter BYTE_SWAP, default 0; 0 = low byte sent first, 1 = high byte sent first.
REQ-003 SHALL have port clk_sys, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tx_data, input, 16, the word to transmit, sampled on acceptance.
REQ-006 SHALL have port tx_vld, input, 1, one-cycle request strobe for tx_data.
REQ-007 SHALL have port tx_done, output, 1, one-cycle pulse when a whole word has left the line.
REQ-008 SHALL have port tx_busy, output, 1, high while a word is in flight.
REQ-009 SHALL have port tx_ovf, output, 1, one-cycle pulse when tx_vld arrives while busy.
REQ-010 SHALL have port uart_tx, output, 1, serial line, idle high.

Function
REQ-011 SHALL accept tx_vld only when tx_busy=0, latch tx_data into a 16-bit holding register, and set tx_busy on the next edge.
REQ-012 SHALL drop tx_vld while tx_busy=1: no effect on the frame in progress, tx_ovf pulsed the next cycle.
REQ-013 SHALL run FSM IDLE -> START -> DATA -> [PARITY] -> STOP, then to START for byte 1, or to IDLE after byte 2.
REQ-014 SHALL hold each state for exactly CLK_DIV cycles, timed by a bit counter that reloads at every state change.
REQ-015 SHALL drive uart_tx low in START, high in STOP, and high in IDLE.
REQ-016 SHALL send 8 data bits LSB first in DATA, tracked by a 3-bit index; DATA lasts 8*CLK_DIV cycles.
REQ-017 SHALL start byte 1's START immediately after byte 0's STOP, with no idle gap.
REQ-018 SHALL drive uart_tx low (START) in the cycle after the acceptance edge; latency tx_vld to falling edge = 1 cycle.
REQ-019 SHALL pulse tx_done and clear tx_busy in the same cycle FSM enters IDLE, i.e. the cycle after the last STOP cycle.
REQ-020 SHALL accept a tx_vld coinciding with the tx_done cycle, giving back-to-back words with a 1-cycle idle-high gap.
REQ-021 SHALL make all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-022 SHALL, on rst_n low, immediately force uart_tx=1, tx_busy=0, tx_done=0, tx_ovf=0, FSM=IDLE, and clear all counters and the holding register.
REQ-023 SHALL abandon any frame in progress on reset mid-operation, with no tx_done issued for it.
REQ-024 SHALL release reset to IDLE, ready to accept tx_vld on the first edge with rst_n high.

Configuration
REQ-025 SHALL insert the PARITY state after DATA when macro CHIP_UART_TX_PARITY_EN is defined.
REQ-026 SHALL, with CHIP_UART_TX_PARITY_EN, drive the PARITY bit as even parity (XOR of the 8 data bits) for CLK_DIV cycles.
REQ-027 SHALL, with CHIP_UART_TX_PARITY_EN, give word time 22*CLK_DIV+1 cycles from acceptance to tx_done.
REQ-028 SHALL, without CHIP_UART_TX_PARITY_EN, contain no parity logic and give word time 20*CLK_DIV+1 cycles.

Verification
REQ-029 SHALL cover basic word, CLK_DIV=4, no parity: tx_data=16'hA53C pulse -> line 0,0011_1100(LSB first),1,0,1010_0101,1; tx_done at cycle 81; tx_busy high cycles 1..80.
REQ-030 SHALL cover parity, macro defined, CLK_DIV=4: tx_data=16'h0301 -> parity bits 1 (byte 01) then 0 (byte 03); tx_done at cycle 89.
REQ-031 SHALL cover overflow: second tx_vld with 16'hFFFF at cycle 10 -> tx_ovf pulse at cycle 11, transmitted bits unchanged, single tx_done.
REQ-032 SHALL cover back-to-back: tx_vld with 16'h1234 in the tx_done cycle of the previous word -> accepted, START 1 cycle later, no tx_ovf.
REQ-033 SHALL cover reset mid-frame: rst_n low at cycle 30 -> uart_tx=1 and tx_busy=0 asynchronously, no tx_done; next word 16'h00FF transmits correctly.
REQ-034 SHALL cover BYTE_SWAP=1: tx_data=16'hA53C -> byte 8'hA5 sent before 8'h3C.
